// File: rtl/asic_cfg_pkg.sv
// -----------------------------------------------------------------------------
// asic_cfg_pkg
// Shared definitions for the ASIC configuration link receiver:
//   - default dynamic / static word lengths
//   - 2-bit frame error codes reported on err_code
//   - receiver FSM state encoding
//   - saturating increment used by the 7-bit received-bit counter
// -----------------------------------------------------------------------------
package asic_cfg_pkg;

  localparam int SIZESRDYN_DEF  = 16;
  localparam int SIZESRSTAT_DEF = 88;

  // Bit counter is 7 bits wide so that an over-long static frame is still
  // distinguishable from a legal one (it saturates at 127).
  localparam int BIT_CNT_W = 7;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_LENGTH   = 2'b01,
    ERR_SEL      = 2'b10,
    ERR_OVERFLOW = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] v);
    return (v == '1) ? v : v + BIT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cfg_sync_edge.sv
// -----------------------------------------------------------------------------
// cfg_sync_edge
// Multi-flop synchronizer for signals asynchronous to CLK, with an optional
// rising-edge detector on the synchronized output.
// Parameters:
//   WIDTH        number of independent lanes
//   SYNC_STAGES  synchronizer depth (>= 2)
//   EDGE_EN      1: rise_o is a one-CLK strobe per lane on a synchronized 0->1
//                0: rise_o tied low, no edge flops
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   data_i       asynchronous inputs
//   data_o       synchronized levels
//   rise_o       rising-edge strobes (synchronized domain)
// -----------------------------------------------------------------------------
module cfg_sync_edge #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] prev_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) prev_q <= '0;
        else        prev_q <= data_o;
      end

      assign rise_o = data_o & ~prev_q;
    end else begin : g_no_edge
      assign rise_o = '0;
    end
  endgenerate

endmodule

// File: rtl/asic_cfg_deserializer.sv
// -----------------------------------------------------------------------------
// asic_cfg_deserializer
// Receive side of the ASIC configuration serial link. Oversamples the gated
// serial clock, data and select lines with CLK, rebuilds the 16-bit DYNCNF and
// 88-bit STATCNF words and flags malformed frames. A frame closes after
// TIMEOUT_CYCLES CLK cycles without an SCLK rise.
//
// Ports:
//   CLK, RST_N   fast sampling clock (>= 8x SCLK), asynchronous active-low reset
//   SCLK_IN      gated serial clock, asynchronous to CLK
//   SDI          serial data, MSB first, sampled on SCLK rise
//   SEL_IN       word select: 1 = dynamic, 0 = static
//   dyn_reg      last good dynamic word
//   stat_reg     last good static word
//   dyn_valid    1-cycle pulse, dyn_reg updated
//   stat_valid   1-cycle pulse, stat_reg updated
//   frame_err    1-cycle pulse, frame discarded
//   err_code     00 none, 01 length, 10 SEL change, 11 overflow;
//                held until the next frame closes
//   busy         high while a frame is being received
//
// Optional build macro CFG_READBACK_CMP_EN:
//   adds inputs exp_dyn / exp_stat and output cmp_mismatch, which on every
//   dyn_valid / stat_valid is set to (received word != expected word) and
//   holds until the next valid.
// -----------------------------------------------------------------------------
module asic_cfg_deserializer
  import asic_cfg_pkg::*;
#(
  parameter int SIZESRDYN      = SIZESRDYN_DEF,
  parameter int SIZESRSTAT     = SIZESRSTAT_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCLK_IN,
  input  logic                  SDI,
  input  logic                  SEL_IN,
`ifdef CFG_READBACK_CMP_EN
  input  logic [SIZESRDYN-1:0]  exp_dyn,
  input  logic [SIZESRSTAT-1:0] exp_stat,
  output logic                  cmp_mismatch,
`endif
  output logic [SIZESRDYN-1:0]  dyn_reg,
  output logic [SIZESRSTAT-1:0] stat_reg,
  output logic                  dyn_valid,
  output logic                  stat_valid,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [BIT_CNT_W-1:0] DYN_LEN   = BIT_CNT_W'(SIZESRDYN);
  localparam logic [BIT_CNT_W-1:0] STAT_LEN  = BIT_CNT_W'(SIZESRSTAT);
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchronizers: SCLK gets an edge detector, SDI/SEL are plain level syncs.
  // Both paths have the same depth, so SDI/SEL are aligned with the rise strobe.
  // ---------------------------------------------------------------------------
  logic       sclk_level;
  logic       sclk_rise;
  logic [1:0] data_sync;
  logic [1:0] data_rise;
  logic       sdi_sync;
  logic       sel_sync;

  cfg_sync_edge #(
    .WIDTH      (1),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_EN    (1'b1)
  ) u_sync_sclk (
    .CLK   (CLK),
    .RST_N (RST_N),
    .data_i(SCLK_IN),
    .data_o(sclk_level),
    .rise_o(sclk_rise)
  );

  cfg_sync_edge #(
    .WIDTH      (2),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_EN    (1'b0)
  ) u_sync_data (
    .CLK   (CLK),
    .RST_N (RST_N),
    .data_i({SEL_IN, SDI}),
    .data_o(data_sync),
    .rise_o(data_rise)
  );

  assign sdi_sync = data_sync[0];
  assign sel_sync = data_sync[1];

  logic [2:0] sync_unused;
  assign sync_unused = {sclk_level, data_rise};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,      state_d;
  logic [SIZESRSTAT-1:0]   shreg_q,      shreg_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [IDLE_W-1:0]       idle_cnt_q,   idle_cnt_d;
  logic                    sel_frame_q,  sel_frame_d;
  logic                    sel_err_q,    sel_err_d;
  logic [SIZESRDYN-1:0]    dyn_reg_q,    dyn_reg_d;
  logic [SIZESRSTAT-1:0]   stat_reg_q,   stat_reg_d;
  logic                    dyn_valid_q,  dyn_valid_d;
  logic                    stat_valid_q, stat_valid_d;
  logic                    frame_err_q,  frame_err_d;
  err_code_e               err_code_q,   err_code_d;
`ifdef CFG_READBACK_CMP_EN
  logic                    cmp_q,        cmp_d;
`endif

  logic [SIZESRSTAT-1:0] shift_val;
  assign shift_val = {shreg_q[SIZESRSTAT-2:0], sdi_sync};

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    sel_frame_d  = sel_frame_q;
    sel_err_d    = sel_err_q;
    dyn_reg_d    = dyn_reg_q;
    stat_reg_d   = stat_reg_q;
    dyn_valid_d  = 1'b0;
    stat_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
`ifdef CFG_READBACK_CMP_EN
    cmp_d        = cmp_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (sclk_rise) begin
          state_d     = SHIFT;
          shreg_d     = shift_val;
          bit_cnt_d   = BIT_CNT_W'(1);
          idle_cnt_d  = '0;
          sel_frame_d = sel_sync;
          sel_err_d   = 1'b0;
        end
      end

      SHIFT: begin
        if (sclk_rise) begin
          shreg_d    = shift_val;
          bit_cnt_d  = sat_inc(bit_cnt_q);
          idle_cnt_d = '0;
          if (sel_sync != sel_frame_q) sel_err_d = 1'b1;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = COMMIT;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end

      COMMIT: begin
        state_d    = IDLE;
        bit_cnt_d  = '0;
        idle_cnt_d = '0;
        sel_err_d  = 1'b0;

        if (bit_cnt_q > STAT_LEN) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERFLOW;
        end else if (sel_err_q) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_SEL;
        end else if (sel_frame_q && (bit_cnt_q == DYN_LEN)) begin
          dyn_reg_d   = shreg_q[SIZESRDYN-1:0];
          dyn_valid_d = 1'b1;
          err_code_d  = ERR_NONE;
`ifdef CFG_READBACK_CMP_EN
          cmp_d       = (shreg_q[SIZESRDYN-1:0] != exp_dyn);
`endif
        end else if (!sel_frame_q && (bit_cnt_q == STAT_LEN)) begin
          stat_reg_d   = shreg_q;
          stat_valid_d = 1'b1;
          err_code_d   = ERR_NONE;
`ifdef CFG_READBACK_CMP_EN
          cmp_d        = (shreg_q != exp_stat);
`endif
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_LENGTH;
        end

        // A rise landing in this cycle opens the next frame; the evaluation
        // above already used the pre-edge shift register and sel_frame.
        if (sclk_rise) begin
          state_d     = SHIFT;
          shreg_d     = shift_val;
          bit_cnt_d   = BIT_CNT_W'(1);
          sel_frame_d = sel_sync;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      sel_frame_q  <= 1'b0;
      sel_err_q    <= 1'b0;
      dyn_reg_q    <= '0;
      stat_reg_q   <= '0;
      dyn_valid_q  <= 1'b0;
      stat_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      sel_frame_q  <= sel_frame_d;
      sel_err_q    <= sel_err_d;
      dyn_reg_q    <= dyn_reg_d;
      stat_reg_q   <= stat_reg_d;
      dyn_valid_q  <= dyn_valid_d;
      stat_valid_q <= stat_valid_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

`ifdef CFG_READBACK_CMP_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cmp_q <= 1'b0;
    else        cmp_q <= cmp_d;
  end

  assign cmp_mismatch = cmp_q;
`endif

  assign dyn_reg    = dyn_reg_q;
  assign stat_reg   = stat_reg_q;
  assign dyn_valid  = dyn_valid_q;
  assign stat_valid = stat_valid_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_asic_cfg_deserializer.sv
// -----------------------------------------------------------------------------
// tb_asic_cfg_deserializer
// Directed bench for asic_cfg_deserializer. CLK period 32 time units, serial
// clock period 512 (16 CLK cycles), SDI/SEL change on the SCLK fall.
// Expected frame outcomes are queued as frames are sent and compared when the
// DUT pulses dyn_valid / stat_valid / frame_err.
// Build with CFG_READBACK_CMP_EN defined to also exercise cmp_mismatch.
// -----------------------------------------------------------------------------
module tb_asic_cfg_deserializer;
  import asic_cfg_pkg::*;

  localparam int CLK_HALF  = 16;
  localparam int SCLK_HALF = 256;
  localparam int DRAIN_MAX = 400;

  logic        CLK;
  logic        RST_N;
  logic        SCLK_IN;
  logic        SDI;
  logic        SEL_IN;
  logic [15:0] dyn_reg;
  logic [87:0] stat_reg;
  logic        dyn_valid;
  logic        stat_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
  logic [15:0] exp_dyn;
  logic [87:0] exp_stat;
`ifdef CFG_READBACK_CMP_EN
  logic        cmp_mismatch;
`endif

  asic_cfg_deserializer dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .SCLK_IN     (SCLK_IN),
    .SDI         (SDI),
    .SEL_IN      (SEL_IN),
`ifdef CFG_READBACK_CMP_EN
    .exp_dyn     (exp_dyn),
    .exp_stat    (exp_stat),
    .cmp_mismatch(cmp_mismatch),
`endif
    .dyn_reg     (dyn_reg),
    .stat_reg    (stat_reg),
    .dyn_valid   (dyn_valid),
    .stat_valid  (stat_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #(CLK_HALF) CLK = ~CLK;

  typedef struct {
    logic [2:0]  pulses;  // {dyn_valid, stat_valid, frame_err}
    logic [1:0]  err;
    logic [15:0] dyn;
    logic [87:0] stat;
    logic        cmp;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference state of the receiver's held outputs.
  logic [15:0] model_dyn  = '0;
  logic [87:0] model_stat = '0;
  logic        model_cmp  = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] pulses, input logic [1:0] err);
    exp_t e;
    e.pulses = pulses;
    e.err    = err;
    e.dyn    = model_dyn;
    e.stat   = model_stat;
    e.cmp    = model_cmp;
    sb.push_back(e);
  endtask

  task automatic expect_dyn(input logic [15:0] val);
    model_dyn = val;
    model_cmp = (val != exp_dyn);
    push(3'b100, ERR_NONE);
  endtask

  task automatic expect_stat(input logic [87:0] val);
    model_stat = val;
    model_cmp  = (val != exp_stat);
    push(3'b010, ERR_NONE);
  endtask

  task automatic expect_err(input logic [1:0] code);
    push(3'b001, code);
  endtask

  // Sends nbits of data MSB first; SEL flips to ~sel from bit index flip_at on.
  task automatic send_frame(input logic [127:0] data, input int nbits,
                            input logic sel, input int flip_at);
    for (int i = 0; i < nbits; i++) begin
      SDI    = data[nbits-1-i];
      SEL_IN = (i >= flip_at) ? ~sel : sel;
      #(SCLK_HALF);
      SCLK_IN = 1'b1;
      #(SCLK_HALF);
      SCLK_IN = 1'b0;
    end
  endtask

  // Bounded wait for all queued outcomes, then confirm the pulse was single-cycle.
  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < DRAIN_MAX) begin
      @(negedge CLK);
      n++;
    end
    check(tag, sb.size(), 0);
    @(negedge CLK);
    check({tag, "_pulse_clear"}, {dyn_valid, stat_valid, frame_err}, 3'b000);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dyn_reg"},    dyn_reg,    16'h0);
    check({tag, "_stat_reg"},   stat_reg,   88'h0);
    check({tag, "_pulses"},     {dyn_valid, stat_valid, frame_err}, 3'b000);
    check({tag, "_err_code"},   err_code,   2'b00);
    check({tag, "_busy"},       busy,       1'b0);
`ifdef CFG_READBACK_CMP_EN
    check({tag, "_cmp"},        cmp_mismatch, 1'b0);
`endif
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (RST_N && (dyn_valid || stat_valid || frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {dyn_valid, stat_valid, frame_err}, 3'b000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pulses",   {dyn_valid, stat_valid, frame_err}, e.pulses);
        check("sb_err_code", err_code, e.err);
        check("sb_dyn_reg",  dyn_reg,  e.dyn);
        check("sb_stat_reg", stat_reg, e.stat);
`ifdef CFG_READBACK_CMP_EN
        check("sb_cmp",      cmp_mismatch, e.cmp);
`endif
      end
    end
  end

  localparam logic [87:0] STAT_WORD = 88'h0123456789ABCDEF012345;
  localparam int          NO_FLIP   = 1000;

  initial begin
    RST_N    = 1'b0;
    SCLK_IN  = 1'b0;
    SDI      = 1'b0;
    SEL_IN   = 1'b0;
    exp_dyn  = 16'hA5C3;
    exp_stat = STAT_WORD;

    // Reset state
    #5;
    check_all_zero("reset");
    repeat (4) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    // 1: dynamic word
    expect_dyn(16'hA5C3);
    send_frame(128'hA5C3, 16, 1'b1, NO_FLIP);
    check("t1_busy_in_frame", busy, 1'b1);
    wait_drain("t1_dyn");

    // 2: static word
    expect_stat(STAT_WORD);
    send_frame({40'h0, STAT_WORD}, 88, 1'b0, NO_FLIP);
    wait_drain("t2_stat");

    // 3: short dynamic frame -> length error, registers kept
    expect_err(ERR_LENGTH);
    send_frame(128'h7E5A, 15, 1'b1, NO_FLIP);
    wait_drain("t3_short");
    repeat (20) @(negedge CLK);
    check("t3_err_held", err_code, ERR_LENGTH);

    // 4: SEL changes from bit index 8 of a static frame
    expect_err(ERR_SEL);
    send_frame({40'h0, 88'hFEDCBA9876543210FEDCBA}, 88, 1'b0, 8);
    wait_drain("t4_sel");

    // 5: 90 rises -> overflow, then a clean dynamic frame clears err_code
    expect_err(ERR_OVERFLOW);
    send_frame(128'h3_5555_AAAA_1234_5678_9ABC_DEF0, 90, 1'b0, NO_FLIP);
    wait_drain("t5_ovf");
    exp_dyn = 16'h5A3C;
    expect_dyn(16'h5A3C);
    send_frame(128'h5A3C, 16, 1'b1, NO_FLIP);
    wait_drain("t5_recover");
    check("t5_err_cleared", err_code, ERR_NONE);

    // 6: reset in the middle of a static frame
    send_frame({40'h0, STAT_WORD}, 40, 1'b0, NO_FLIP);
    check("t6_busy_before_rst", busy, 1'b1);
    RST_N = 1'b0;
    #5;
    check_all_zero("t6_rst");
    model_dyn  = '0;
    model_stat = '0;
    model_cmp  = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (150) @(negedge CLK);
    check("t6_no_pending", sb.size(), 0);
    exp_dyn = 16'h1235;
    expect_dyn(16'h1234);
    send_frame(128'h1234, 16, 1'b1, NO_FLIP);
    wait_drain("t6_dyn");
    check("t6_dyn_reg_final", dyn_reg, 16'h1234);
`ifdef CFG_READBACK_CMP_EN
    check("t6_cmp_mismatch", cmp_mismatch, 1'b1);
`endif

    repeat (10) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
